pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen_if.sv | 26 ++
 rtl/pc_gen_redirect_buf.sv | 40 ++++
 rtl/pc_gen.sv | 136 +++++++++++++
 tb/tb_pc_gen.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator: FSM state codes, stall polarity,
// zero word and the sequential PC increment.
package pc_gen_pkg;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic addr_misaligned(input logic [1:0] lo);
    return |lo;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: pipeline control and redirect inputs, fetch
// request outputs.
interface pc_gen_if #(
  parameter int PC_W    = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [PC_W-1:0]    flush_pc;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               req_ready;
  logic [PC_W-1:0]    o_pc;
  logic               o_valid;
  logic               o_adel;

  modport master (
    output stall, flush, flush_pc, br_taken, br_target, req_ready,
    input  o_pc, o_valid, o_adel
  );

  modport slave (
    input  stall, flush, flush_pc, br_taken, br_target, req_ready,
    output o_pc, o_valid, o_adel
  );
endinterface

// File: rtl/pc_gen_redirect_buf.sv
// Holds a branch target that could not be taken immediately because the
// current fetch was not yet accepted.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_target,
  output logic            o_valid
);

  logic [PC_W-1:0] r_target;
  logic            r_valid;

  // Clear wins over load so a flush always discards a branch seen in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_target <= PC_W'(ZERO_WORD);
      r_valid  <= 1'b0;
    end else if (i_clr) begin
      r_target <= PC_W'(ZERO_WORD);
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_target <= i_target;
      r_valid  <= 1'b1;
    end else begin
      r_target <= r_target;
      r_valid  <= r_valid;
    end
  end

  assign o_target = r_target;
  assign o_valid  = r_valid;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential increment, branch and flush redirection with
// stall/backpressure handling. All outputs are registered.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = 32'hBFC0_0000,
  parameter int              STALL_W   = 6
) (
  input  logic clk,
  input  logic reset,
  pc_gen_if.slave bus
);

  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_adel;
  logic [1:0]      r_state;

  logic [PC_W-1:0] w_pc_nxt;
  logic            w_valid_nxt;
  logic [1:0]      w_state_nxt;
  logic            w_buf_clr;
  logic            w_buf_load;
  logic [PC_W-1:0] w_pend_target;
  logic            w_pend_vld;
  logic            w_advance;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_unused;

  assign w_unused  = &{1'b0, bus.stall[STALL_W-1:2]};
  assign w_advance = r_valid & bus.req_ready & (bus.stall[0] == NO_STOP);
  assign w_pc_inc  = r_pc + PC_W'(PC_INC);

  pc_redirect_buf #(.PC_W(PC_W)) u_redirect_buf (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_buf_clr),
    .i_load   (w_buf_load),
    .i_target (bus.br_target),
    .o_target (w_pend_target),
    .o_valid  (w_pend_vld)
  );

  // Next-state logic: flush overrides everything, then per-state redirect/advance.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_state_nxt = r_state;
    w_buf_clr   = 1'b0;
    w_buf_load  = 1'b0;

    if (bus.stall[0] == NO_STOP) begin
      w_valid_nxt = 1'b1;
    end else if (bus.stall[1] == NO_STOP) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_valid;
    end

    if (bus.flush) begin
      w_pc_nxt    = bus.flush_pc;
      w_valid_nxt = 1'b1;
      w_buf_clr   = 1'b1;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (bus.stall[0] == STOP) begin
            w_state_nxt = ST_INIT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.br_taken) begin
            if (w_advance) begin
              w_pc_nxt = bus.br_target;
            end else begin
              w_buf_load  = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end else if (w_advance) begin
            w_pc_nxt = w_pc_inc;
          end else begin
            w_pc_nxt = r_pc;
          end
        end
        ST_HOLD: begin
          if (w_advance) begin
            // A branch arriving on the accepting edge supersedes the buffered one.
            if (bus.br_taken) begin
              w_pc_nxt = bus.br_target;
            end else if (w_pend_vld) begin
              w_pc_nxt = w_pend_target;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
            w_buf_clr   = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (bus.br_taken) begin
            w_buf_load = 1'b1;
          end else begin
            w_buf_load = 1'b0;
          end
        end
        default: begin
          w_pc_nxt    = RESET_VEC;
          w_valid_nxt = 1'b0;
          w_buf_clr   = 1'b1;
          w_state_nxt = ST_INIT;
        end
      endcase
    end
  end

  // Output and state registers; misalignment flag derived from the next fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
      r_state <= ST_INIT;
    end else begin
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_adel  <= w_valid_nxt & addr_misaligned(w_pc_nxt[1:0]);
      r_state <= w_state_nxt;
    end
  end

  assign bus.o_pc    = r_pc;
  assign bus.o_valid = r_valid;
  assign bus.o_adel  = r_adel;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized self-checking bench for pc_gen against a behavioural fetch model,
// preceded by directed redirect, stall, wrap and reset scenarios.
module tb_pc_gen;

  localparam logic [31:0] RST_VEC = 32'hBFC0_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_started;
  logic        m_has_pend;
  logic [31:0] m_pend;

  pc_gen_if #(.PC_W(32), .STALL_W(6)) bus ();

  pc_gen #(.PC_W(32), .RESET_VEC(32'hBFC0_0000), .STALL_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = RST_VEC;
    m_valid    = 1'b0;
    m_started  = 1'b0;
    m_has_pend = 1'b0;
    m_pend     = 32'h0;
  endtask

  task automatic model_step(input logic [5:0] st, input logic fl, input logic [31:0] fpc,
                            input logic br, input logic [31:0] bt, input logic rdy);
    logic take;
    take = m_valid && rdy && !st[0];
    if (fl) begin
      m_pc       = fpc;
      m_valid    = 1'b1;
      m_started  = 1'b1;
      m_has_pend = 1'b0;
    end else begin
      if (!m_started) begin
        if (!st[0]) m_started = 1'b1;
      end else if (m_has_pend) begin
        if (take) begin
          m_pc       = br ? bt : m_pend;
          m_has_pend = 1'b0;
        end else if (br) begin
          m_pend = bt;
        end
      end else if (br) begin
        if (take) m_pc = bt;
        else begin
          m_pend     = bt;
          m_has_pend = 1'b1;
        end
      end else if (take) begin
        m_pc = m_pc + 32'd4;
      end
      if (!st[0])      m_valid = 1'b1;
      else if (!st[1]) m_valid = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".pc"},    bus.o_pc, m_pc);
    check_val({tag, ".valid"}, {31'd0, bus.o_valid}, {31'd0, m_valid});
    check_val({tag, ".adel"},  {31'd0, bus.o_adel}, {31'd0, m_valid & (|m_pc[1:0])});
  endtask

  task automatic step(input string tag, input logic [5:0] st, input logic fl, input logic [31:0] fpc,
                      input logic br, input logic [31:0] bt, input logic rdy);
    reset         = 1'b1;
    bus.stall     = st;
    bus.flush     = fl;
    bus.flush_pc  = fpc;
    bus.br_taken  = br;
    bus.br_target = bt;
    bus.req_ready = rdy;
    model_step(st, fl, fpc, br, bt, rdy);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #2;
    check_model(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.stall = 6'd0; bus.flush = 1'b0; bus.flush_pc = 32'd0;
    bus.br_taken = 1'b0; bus.br_target = 32'd0; bus.req_ready = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");

    // Boot sequence
    step("boot1", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("boot1.pc", bus.o_pc, 32'hBFC0_0000);
    step("boot2", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step("boot3", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("boot3.pc", bus.o_pc, 32'hBFC0_0008);

    // Branch under full stall, then release
    step("hold1", 6'b000011, 1'b0, 32'd0, 1'b1, 32'h8000_1000, 1'b1);
    step("hold2", 6'b000011, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step("hold3", 6'b000011, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("hold3.pc", bus.o_pc, 32'hBFC0_0008);
    step("hold_rel", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("hold_rel.pc", bus.o_pc, 32'h8000_1000);

    // Flush beats branch and stall
    step("flush", 6'b111111, 1'b1, 32'hBFC0_0380, 1'b1, 32'h1234_5678, 1'b0);
    check_val("flush.pc", bus.o_pc, 32'hBFC0_0380);
    check_val("flush.valid", {31'd0, bus.o_valid}, 32'd1);
    step("flush_nxt", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("flush_nxt.pc", bus.o_pc, 32'hBFC0_0384);

    // Bubble
    step("bub_set", 6'd0, 1'b1, 32'hBFC0_0010, 1'b0, 32'd0, 1'b0);
    step("bub1", 6'b000001, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step("bub2", 6'b000001, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("bub2.valid", {31'd0, bus.o_valid}, 32'd0);
    check_val("bub2.pc", bus.o_pc, 32'hBFC0_0010);
    step("bub_rel", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_val("bub_rel.valid", {31'd0, bus.o_valid}, 32'd1);
    check_val("bub_rel.pc", bus.o_pc, 32'hBFC0_0010);

    // Misaligned target and wrap
    step("mis", 6'd0, 1'b0, 32'd0, 1'b1, 32'h8000_0002, 1'b1);
    check_val("mis.adel", {31'd0, bus.o_adel}, 32'd1);
    step("wrap_set", 6'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1);
    step("wrap", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("wrap.pc", bus.o_pc, 32'h0000_0000);

    // Reset while a redirect is pending
    step("pend", 6'd0, 1'b0, 32'd0, 1'b1, 32'h8000_4000, 1'b0);
    async_reset("rst_hold");
    check_val("rst_hold.pc", bus.o_pc, 32'hBFC0_0000);
    check_val("rst_hold.valid", {31'd0, bus.o_valid}, 32'd0);
    step("rst_rel1", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step("rst_rel2", 6'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check_val("rst_rel2.pc", bus.o_pc, 32'hBFC0_0004);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [5:0]  st;
      logic        fl;
      logic        br;
      logic        rdy;
      logic [31:0] fpc;
      logic [31:0] bt;
      st  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      fl  = ($urandom_range(0, 15) == 0);
      br  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      fpc = $urandom;
      bt  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        fpc[1:0] = 2'b00;
        bt[1:0]  = 2'b00;
      end
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      step("rnd", st, fl, fpc, br, bt, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
